// File: rtl/vro_pkg.sv
// Shared definitions for the vector-reverse-ordering scheduler:
// default burst geometry, FSM state encoding and requester ids.
package vro_pkg;

    localparam int VRO_LEN  = 6;   // elements per burst
    localparam int VRO_W    = 3;   // element width
    localparam int VRO_WDOG = 15;  // idle cycles tolerated while waiting on the engine

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } vro_state_e;

    localparam logic OWN0 = 1'b0;
    localparam logic OWN1 = 1'b1;

endpackage

// File: rtl/vro_sched_if.sv
// Bundle of requester-side and engine-side signals around the scheduler.
// master: the scheduler itself; slave: requesters plus engine.
interface vro_sched_if #(
    parameter int W = vro_pkg::VRO_W
);
    logic         req0;
    logic         req1;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic         gnt0;
    logic         gnt1;
    logic         eng_in_valid;
    logic [W-1:0] eng_in;
    logic         eng_out_valid;
    logic [W-1:0] eng_out;
    logic         out0_valid;
    logic [W-1:0] out0;
    logic         out1_valid;
    logic [W-1:0] out1;
    logic         err;

    modport master (
        input  req0, req1, data0, data1, eng_out_valid, eng_out,
        output gnt0, gnt1, eng_in_valid, eng_in, out0_valid, out0, out1_valid, out1, err
    );

    modport slave (
        output req0, req1, data0, data1, eng_out_valid, eng_out,
        input  gnt0, gnt1, eng_in_valid, eng_in, out0_valid, out0, out1_valid, out1, err
    );
endinterface

// File: rtl/vro_rr_arb.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the requester that was not served last.
module vro_rr_arb
    import vro_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic owner_o
);

    // Combinational owner selection from the current requests and last winner
    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            owner_o = ~last_i;
        end else if (req1_i) begin
            owner_o = OWN1;
        end else begin
            owner_o = OWN0;
        end
    end

endmodule

// File: rtl/vro_sched.sv
// Scheduler sharing one vector-reverse engine between two requesters:
// grant one burst, stream it into the engine, wait for the reversed burst
// and route it back to its owner. A watchdog aborts a stalled engine.
module vro_sched
    import vro_pkg::*;
#(
    parameter int LEN  = VRO_LEN,
    parameter int W    = VRO_W,
    parameter int WDOG = VRO_WDOG
) (
    input  logic         clk,
    input  logic         rst_n,
    vro_sched_if.master  bus
);

    localparam int CNT_W = $clog2(LEN) + 1;
    localparam int WD_W  = $clog2(WDOG + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WDOG);

    vro_state_e       state_q;
    logic             owner_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WD_W-1:0]  wdog_q;
    logic [WD_W-1:0]  wdog_d;
    logic             wdog_exp_s;

    logic             gnt0_q;
    logic             gnt1_q;
    logic             eng_in_valid_q;
    logic [W-1:0]     eng_in_q;
    logic             out0_valid_q;
    logic [W-1:0]     out0_q;
    logic             out1_valid_q;
    logic [W-1:0]     out1_q;
    logic             err_q;

    logic             arb_valid_s;
    logic             arb_owner_s;
    logic [W-1:0]     data_own_s;

    vro_rr_arb u_arb (
        .req0_i  (bus.req0),
        .req1_i  (bus.req1),
        .last_i  (last_q),
        .valid_o (arb_valid_s),
        .owner_o (arb_owner_s)
    );

    // Select the granted requester's element for the engine input register
    always_comb begin
        if (owner_q == OWN1) begin
            data_own_s = bus.data1;
        end else begin
            data_own_s = bus.data0;
        end
    end

    // Watchdog next count and expiry: expiry fires when the count would reach WDOG
    always_comb begin
        wdog_d     = wdog_q + WD_W'(1);
        wdog_exp_s = (wdog_d == WD_LIMIT);
    end

    // Scheduler FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN0;
            last_q         <= OWN1;
            cnt_q          <= '0;
            wdog_q         <= '0;
            gnt0_q         <= 1'b0;
            gnt1_q         <= 1'b0;
            eng_in_valid_q <= 1'b0;
            eng_in_q       <= '0;
            out0_valid_q   <= 1'b0;
            out0_q         <= '0;
            out1_valid_q   <= 1'b0;
            out1_q         <= '0;
            err_q          <= 1'b0;
        end else begin
            eng_in_valid_q <= 1'b0;
            eng_in_q       <= '0;
            out0_valid_q   <= 1'b0;
            out0_q         <= '0;
            out1_valid_q   <= 1'b0;
            out1_q         <= '0;
            err_q          <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // engine beats arriving here are dropped on purpose
                    if (arb_valid_s) begin
                        owner_q <= arb_owner_s;
                        gnt0_q  <= (arb_owner_s == OWN0);
                        gnt1_q  <= (arb_owner_s == OWN1);
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    eng_in_valid_q <= 1'b1;
                    eng_in_q       <= data_own_s;
                    if (cnt_q == CNT_LAST) begin
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        last_q  <= owner_q;
                        cnt_q   <= '0;
                        wdog_q  <= '0;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT, ST_RETURN: begin
                    if (bus.eng_out_valid) begin
                        wdog_q <= '0;
                        if (owner_q == OWN0) begin
                            out0_valid_q <= 1'b1;
                            out0_q       <= bus.eng_out;
                        end else begin
                            out1_valid_q <= 1'b1;
                            out1_q       <= bus.eng_out;
                        end
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= ST_RETURN;
                        end
                    end else if (wdog_exp_s) begin
                        err_q   <= 1'b1;
                        wdog_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        wdog_q  <= wdog_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0         = gnt0_q;
    assign bus.gnt1         = gnt1_q;
    assign bus.eng_in_valid = eng_in_valid_q;
    assign bus.eng_in       = eng_in_q;
    assign bus.out0_valid   = out0_valid_q;
    assign bus.out0         = out0_q;
    assign bus.out1_valid   = out1_valid_q;
    assign bus.out1         = out1_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_vro_sched.sv
// Bench for vro_sched: behavioural reversing engine, two requester models,
// a per-cycle monitor, a table of burst scenarios and a few timing sequences.
module tb_vro_sched;
    import vro_pkg::*;

    localparam int LEN  = VRO_LEN;
    localparam int W    = VRO_W;
    localparam int WDOG = VRO_WDOG;
    localparam int M_NORM   = 0;
    localparam int M_GAP    = 1;
    localparam int M_SILENT = 2;

    typedef struct {
        int         n0;      // bursts requester 0 wants
        int         n1;      // bursts requester 1 wants
        int         mode;    // engine behaviour
        int         nb;      // expected number of grants
        logic [3:0] order;   // expected owner of grant i in bit i
        int         nerr;    // expected watchdog pulses
        int         base0;
        int         base1;
    } vec_t;

    logic clk;
    logic rst_n;
    vro_sched_if #(.W(W)) bus();

    vro_sched #(.LEN(LEN), .W(W), .WDOG(WDOG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   eng_mode = M_NORM;
    logic poke     = 1'b0;
    int   rem0 = 0, rem1 = 0, base0 = 0, base1 = 0, bn0 = 0, bn1 = 0;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   gord[$], glen[$], gfirst[$], ein_q[$];
    int   o0_q[$], o0_c[$], o1_q[$], o1_c[$];
    int   err_cnt, err_cyc, proto_viol, zero_viol;
    logic g_prev;
    vec_t vecs[8];

    function automatic int elem(input int base, input int step, input int k, input int bn);
        return (base + step * k + bn) & ((1 << W) - 1);
    endfunction

    function automatic int outs();
        return int'({bus.gnt0, bus.gnt1, bus.eng_in_valid, bus.eng_in, bus.out0_valid,
                     bus.out0, bus.out1_valid, bus.out1, bus.err});
    endfunction

    function automatic int qdiff(input int a[$], input int b[$]);
        int d;
        d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
        return d;
    endfunction

    function automatic int gapviol(input int c[$], input int mode);
        int v, j, expd;
        v = 0;
        for (int i = 1; i < c.size(); i++) begin
            j = i % LEN;
            if (j != 0) begin
                expd = (mode == M_GAP && j == 3) ? 3 : 1;
                if (c[i] - c[i-1] != expd) v++;
            end
        end
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        gord.delete(); glen.delete(); gfirst.delete(); ein_q.delete();
        o0_q.delete(); o0_c.delete(); o1_q.delete(); o1_c.delete();
        err_cnt = 0; err_cyc = -1; proto_viol = 0; zero_viol = 0; g_prev = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0; rem0 = 0; rem1 = 0; bn0 = 0; bn1 = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_clear();
        mon_en = 1'b1;
    endtask

    // Engine model: collects LEN inputs, then returns them reversed
    initial begin : engine
        int mem [LEN];
        int icnt, oidx, estep;
        logic emitting;
        icnt = 0; oidx = 0; estep = 0; emitting = 1'b0;
        bus.eng_out_valid = 1'b0; bus.eng_out = '0;
        forever begin
            @(negedge clk);
            bus.eng_out_valid = 1'b0;
            bus.eng_out = '0;
            if (!rst_n) begin
                icnt = 0; emitting = 1'b0;
            end else begin
                if (poke) begin
                    bus.eng_out_valid = 1'b1; bus.eng_out = W'(5); poke = 1'b0;
                end else if (emitting) begin
                    if (!(eng_mode == M_GAP && (estep == 3 || estep == 4))) begin
                        bus.eng_out_valid = 1'b1;
                        bus.eng_out = W'(mem[LEN-1-oidx]);
                        oidx++;
                    end
                    estep++;
                    if (oidx == LEN) emitting = 1'b0;
                end
                if (bus.eng_in_valid) begin
                    mem[icnt] = int'(bus.eng_in);
                    icnt++;
                    if (icnt == LEN) begin
                        icnt = 0;
                        if (eng_mode != M_SILENT) begin
                            emitting = 1'b1; oidx = 0; estep = 0;
                        end
                    end
                end
            end
        end
    end

    // Requester models: hold req while bursts remain, present element k in k-th grant cycle
    initial begin : requesters
        int k0, k1, cur0, cur1;
        logic p0, p1;
        k0 = 0; k1 = 0; cur0 = 0; cur1 = 0; p0 = 1'b0; p1 = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
        forever begin
            @(negedge clk);
            if (bus.gnt0 && !p0) begin k0 = 0; cur0 = bn0; bn0++; if (rem0 > 0) rem0--; end
            if (bus.gnt1 && !p1) begin k1 = 0; cur1 = bn1; bn1++; if (rem1 > 0) rem1--; end
            if (bus.gnt0) begin bus.data0 = W'(elem(base0, 1, k0, cur0)); k0++; end
            else bus.data0 = '0;
            if (bus.gnt1) begin bus.data1 = W'(elem(base1, 3, k1, cur1)); k1++; end
            else bus.data1 = '0;
            bus.req0 = (rem0 > 0);
            bus.req1 = (rem1 > 0);
            p0 = bus.gnt0;
            p1 = bus.gnt1;
        end
    end

    // Monitor: per-cycle log of grants, engine input, returned data and err
    initial begin : monitor
        logic gnow;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                gnow = bus.gnt0 | bus.gnt1;
                if (bus.gnt0 && bus.gnt1) proto_viol++;
                if (gnow && !g_prev) begin
                    gord.push_back(bus.gnt1 ? 1 : 0); glen.push_back(0); gfirst.push_back(cyc);
                end
                if (gnow) glen[glen.size()-1] = glen[glen.size()-1] + 1;
                if (bus.eng_in_valid != g_prev) proto_viol++;
                if (bus.eng_in_valid) ein_q.push_back(int'(bus.eng_in));
                else if (bus.eng_in != '0) zero_viol++;
                if (bus.out0_valid) begin o0_q.push_back(int'(bus.out0)); o0_c.push_back(cyc); end
                else if (bus.out0 != '0) zero_viol++;
                if (bus.out1_valid) begin o1_q.push_back(int'(bus.out1)); o1_c.push_back(cyc); end
                else if (bus.out1 != '0) zero_viol++;
                if (bus.err) begin
                    if (err_cnt == 0) err_cyc = cyc;
                    err_cnt++;
                end
                g_prev = gnow;
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int exp_ein[$], exp_o0[$], exp_o1[$];
        int c0, c1, own, ordv, lbad;
        do_reset();
        eng_mode = v.mode; base0 = v.base0; base1 = v.base1;
        rem0 = v.n0; rem1 = v.n1;
        repeat (30 * v.nb + 10) @(negedge clk);
        c0 = 0; c1 = 0;
        for (int b = 0; b < v.nb; b++) begin
            own = int'(v.order[b]);
            for (int k = 0; k < LEN; k++)
                exp_ein.push_back(own == 1 ? elem(v.base1, 3, k, c1) : elem(v.base0, 1, k, c0));
            if (v.mode != M_SILENT) begin
                for (int k = LEN - 1; k >= 0; k--) begin
                    if (own == 1) exp_o1.push_back(elem(v.base1, 3, k, c1));
                    else exp_o0.push_back(elem(v.base0, 1, k, c0));
                end
            end
            if (own == 1) c1++; else c0++;
        end
        ordv = 0; lbad = 0;
        for (int i = 0; i < gord.size(); i++) ordv += gord[i] << i;
        for (int i = 0; i < glen.size(); i++) if (glen[i] != LEN) lbad++;
        check($sformatf("v%0d_grants", idx), gord.size(), v.nb);
        check($sformatf("v%0d_order", idx), ordv, int'(v.order));
        check($sformatf("v%0d_gnt_len_bad", idx), lbad, 0);
        check($sformatf("v%0d_proto_viol", idx), proto_viol, 0);
        check($sformatf("v%0d_eng_in_diff", idx), qdiff(ein_q, exp_ein), 0);
        check($sformatf("v%0d_out0_diff", idx), qdiff(o0_q, exp_o0), 0);
        check($sformatf("v%0d_out1_diff", idx), qdiff(o1_q, exp_o1), 0);
        check($sformatf("v%0d_err_cycles", idx), err_cnt, v.nerr);
        check($sformatf("v%0d_zero_viol", idx), zero_viol, 0);
        check($sformatf("v%0d_gap_viol", idx), gapviol(o0_c, v.mode) + gapviol(o1_c, v.mode), 0);
    endtask

    initial begin : main
        int act, gc, glast;
        logic found;
        vecs[0] = '{1, 0, M_NORM,   1, 4'b0000, 0, 1, 7};
        vecs[1] = '{0, 1, M_NORM,   1, 4'b0001, 0, 1, 7};
        vecs[2] = '{1, 1, M_NORM,   2, 4'b0010, 0, 2, 4};
        vecs[3] = '{2, 2, M_NORM,   4, 4'b1010, 0, 3, 1};
        vecs[4] = '{1, 0, M_GAP,    1, 4'b0000, 0, 5, 0};
        vecs[5] = '{0, 1, M_GAP,    1, 4'b0001, 0, 0, 6};
        vecs[6] = '{1, 1, M_SILENT, 2, 4'b0010, 2, 1, 7};
        vecs[7] = '{3, 1, M_NORM,   4, 4'b0010, 0, 6, 2};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 0);
        do_reset();
        repeat (3) @(negedge clk);
        check("idle_outs", outs(), 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Back-to-back: second grant starts one cycle after last returned beat
        do_reset();
        eng_mode = M_NORM; base0 = 1; base1 = 7; rem0 = 1; rem1 = 1;
        repeat (60) @(negedge clk);
        act = (gfirst.size() >= 2 && o0_c.size() > 0) ? gfirst[1] - o0_c[o0_c.size()-1] : -1;
        check("b2b_turnaround", act, 1);

        // Watchdog: err exactly WDOG cycles after entering WAIT, single pulse
        do_reset();
        eng_mode = M_SILENT; base0 = 1; rem0 = 1;
        repeat (40) @(negedge clk);
        glast = (gfirst.size() > 0) ? gfirst[0] + glen[0] - 1 : 0;
        check("wdog_delay", err_cyc - glast - 1, WDOG);
        check("wdog_pulses", err_cnt, 1);
        check("wdog_no_out", o0_q.size() + o1_q.size(), 0);

        // Reset during the third grant cycle, then a fresh full burst
        do_reset();
        eng_mode = M_NORM; base0 = 2; rem0 = 1; gc = 0; found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (bus.gnt0) gc++;
            if (gc == 3) found = 1'b1;
        end
        check("midgrant_reached", int'(found), 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midgrant_rst_outs", outs(), 0);
        do_reset();
        base0 = 4; rem0 = 1;
        repeat (40) @(negedge clk);
        check("post_rst_gnt_len", (glen.size() == 1) ? glen[0] : -1, LEN);
        begin
            int exp_o[$];
            for (int k = LEN - 1; k >= 0; k--) exp_o.push_back(elem(4, 1, k, 0));
            check("post_rst_out0_diff", qdiff(o0_q, exp_o), 0);
        end

        // Engine beat while idle is discarded
        do_reset();
        eng_mode = M_NORM; base0 = 3;
        poke = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_beat_dropped", o0_q.size() + o1_q.size(), 0);
        rem0 = 1;
        repeat (40) @(negedge clk);
        check("after_idle_beat_out0", o0_q.size(), LEN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vro_sched.md
Name: vro_sched

Overview:
- Two-requester scheduler that shares one vector-reverse-ordering engine.
- Grants one requester at a time and streams its LEN-element burst into the engine.
- Waits for the reversed burst, then routes it back to the owning requester.
- Sits between two producer blocks and the single VRO engine instance.

Parameters:
- LEN, 6, elements per vector burst (engine vector length).
- W, 3, element width in bits.
- WDOG, 15, watchdog limit in idle cycles while waiting on engine output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 wants a slot; level, held until gnt0 seen
- req1  in  1  requester 1 request; same rules as req0
- data0  in  W  requester 0 element; must hold element k in the k-th gnt0 cycle
- data1  in  W  requester 1 element
- gnt0  out  1  high exactly LEN consecutive cycles while data0 is sampled
- gnt1  out  1  same for requester 1
- eng_in_valid  out  1  to engine in_valid
- eng_in  out  W  to engine in
- eng_out_valid  in  1  from engine out_valid
- eng_out  in  W  from engine out
- out0_valid  out  1  returned element valid, requester 0
- out0  out  W  returned element, requester 0 (0 when not valid)
- out1_valid  out  1  returned element valid, requester 1
- out1  out  W  returned element, requester 1
- err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE; counters are 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Reset mid-operation aborts immediately. The engine must share rst_n.
- Clocking: single clock; every output is registered.
- FSM states: IDLE, GRANT, WAIT, RETURN.
- IDLE:
  - Sample req0/req1.
  - If exactly one is high, that requester becomes owner.
  - If both are high, owner = !last.
  - Next state is GRANT; gnt_owner rises the following cycle.
  - No request: stay in IDLE.
- GRANT:
  - gnt_owner is high for cnt = 0..LEN-1.
  - Each cycle, data_owner is registered into eng_in and eng_in_valid=1. eng_in_valid therefore trails gnt by exactly 1 cycle and is LEN cycles contiguous.
  - At cnt==LEN-1, go to WAIT and set last=owner.
  - gnt drops the next cycle; eng_in_valid drops one cycle after gnt.
- req handling during GRANT:
  - Deasserting req during GRANT is ignored; the burst completes.
  - The other requester's req is ignored until the next IDLE.
- WAIT:
  - eng_in_valid=0, eng_in=0.
  - The watchdog counts cycles. The first eng_out_valid goes to RETURN, and that beat counts as beat 0.
  - If the watchdog reaches WDOG with no valid, pulse err for 1 cycle and go to IDLE. No outputs are produced for that burst.
- RETURN:
  - Each eng_out_valid beat registers outN_valid=1 and outN=eng_out for the owner (1-cycle latency).
  - The non-owner's out is held at 0.
  - After LEN beats, go to IDLE.
  - A gap in eng_out_valid holds the state. The watchdog resets on every beat and applies the same WDOG/err rule.
- Back-to-back bursts: from IDLE, a new grant starts one cycle after RETURN completes. Minimum turnaround is 1 idle cycle.
- Widths:
  - Burst counter is ceil(log2(LEN))+1 bits.
  - Watchdog counter is ceil(log2(WDOG+1)) bits.
  - No wrap occurs because both counters are compared and cleared before overflow.
- Beats from the engine while in IDLE or GRANT are discarded and do not change state.

Decomposition:
- Shared package vro_pkg holds:
  - LEN and W defaults.
  - State encoding constants ST_IDLE, ST_GRANT, ST_WAIT, ST_RETURN.
  - Owner encoding (0/1).
- One sub-module: vro_rr_arb, a 2-way round-robin pick from req0, req1, last. It outputs a valid bit and the owner.

Test Plan:
- Single request: req0=1, data0 = 1,2,3,4,5,6 over gnt0 → eng_in = 1..6 one cycle after gnt0. With an engine model reversing, out0 = 6,5,4,3,2,1 on 6 contiguous out0_valid cycles; out1_valid stays 0.
- Simultaneous requests after reset: req0=req1=1 → gnt0 first (6 cycles). After RETURN, gnt1 follows, starting 1 cycle after out0's last beat. Returned data is routed to out1 only.
- Round-robin fairness: both requesters hold req for 4 bursts → grant order 0,1,0,1.
- Watchdog: engine model never asserts out_valid → err pulses exactly once, WDOG cycles after entering WAIT. FSM returns to IDLE and a pending req1 is then granted.
- Gapped return: engine emits 3 beats, 2 idle cycles, then 3 beats → 6 out0_valid beats with the same gap and no err.
- Reset mid-GRANT: drop rst_n at cnt=2 → all outputs 0 immediately. After release, a fresh req0 gets a full 6-cycle gnt0.
